// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and requester ids.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } arb_state_e;

    localparam logic ARB_ID_D = 1'b0;
    localparam logic ARB_ID_I = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner select between dcache and icache requests.
// MEM_ARB_ROUND_ROBIN_EN defined: ties alternate on last_grant; otherwise dcache wins ties.
module arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic i_d_req,
    input  logic i_i_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic i_last_grant,
`endif
    output logic o_grant_id
);

    always_comb begin
        o_grant_id = ARB_ID_D;
        if (i_i_req && !i_d_req) begin
            o_grant_id = ARB_ID_I;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        else if (i_i_req && i_d_req && (i_last_grant == ARB_ID_D)) begin
            o_grant_id = ARB_ID_I;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one data memory between the dcache (read/write) and icache (read-only), one transaction
// at a time. Tie policy: MEM_ARB_ROUND_ROBIN_EN selects round robin, else fixed dcache priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic              w_d_req;
    logic              w_i_req;
    logic              w_pick_id;
    logic              w_grant;
    logic              w_finish;
    logic              r_winner;
    logic              r_seen_busy;
    logic              r_d_done;
    logic              r_i_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [DATA_W-1:0] r_d_readdata;
    logic [DATA_W-1:0] r_i_readdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              r_last_grant;
`endif

    assign w_d_req = d_read | d_write;
    assign w_i_req = i_read;

    arb_pick u_arb_pick (
        .i_d_req      (w_d_req),
        .i_i_req      (w_i_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant_id   (w_pick_id)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    if (w_d_req || w_i_req) w_state_next = StGrant;
            StGrant:   if (w_finish) w_state_next = StRelease;
            StRelease: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Completion only after the memory has been seen busy, so a stale low busywait is ignored.
    always_comb begin
        w_grant    = (r_state == StIdle) && (w_d_req || w_i_req);
        w_finish   = (r_state == StGrant) && r_seen_busy && !mem_busywait;
        d_busywait = w_d_req & ~r_d_done;
        i_busywait = w_i_req & ~r_i_done;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_winner        <= ARB_ID_D;
            r_seen_busy     <= 1'b0;
            r_d_done        <= 1'b0;
            r_i_done        <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_d_readdata    <= '0;
            r_i_readdata    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant    <= ARB_ID_I;
`endif
        end else begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
            if (w_grant) begin
                r_winner    <= w_pick_id;
                r_seen_busy <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                r_last_grant <= w_pick_id;
`endif
                if (w_pick_id == ARB_ID_D) begin
                    // Simultaneous read and write from the dcache is a write-back.
                    r_mem_write     <= d_write;
                    r_mem_read      <= ~d_write;
                    r_mem_address   <= d_address;
                    r_mem_writedata <= d_writedata;
                end else begin
                    r_mem_write   <= 1'b0;
                    r_mem_read    <= 1'b1;
                    r_mem_address <= i_address;
                end
            end else if (r_state == StGrant) begin
                if (mem_busywait) begin
                    r_seen_busy <= 1'b1;
                end
                if (w_finish) begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (r_winner == ARB_ID_D) begin
                        r_d_done <= 1'b1;
                        if (r_mem_read) r_d_readdata <= mem_readdata;
                    end else begin
                        r_i_done <= 1'b1;
                        if (r_mem_read) r_i_readdata <= mem_readdata;
                    end
                end
            end
        end
    end

    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;
    assign d_readdata    = r_d_readdata;
    assign i_readdata    = r_i_readdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: behavioural memory plus a reference model of grant
// order and memory contents; follows MEM_ARB_ROUND_ROBIN_EN for the expected tie order.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        d_read, d_write, d_busywait;
    logic [5:0]  d_address;
    logic [31:0] d_writedata, d_readdata;
    logic        i_read, i_busywait;
    logic [5:0]  i_address;
    logic [31:0] i_readdata;
    logic        mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] d_exp;
    logic [31:0] i_exp;
    int          last_exp;

    logic [31:0] store [64];
    int          mem_lat = 3;
    int          m_cnt;
    logic        m_rel, m_op_w;
    logic [5:0]  m_addr;
    logic [31:0] m_wd;

    always #5 clock = ~clock;

    mem_bus_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    function automatic logic [31:0] fill(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'd777;
    endfunction

    // Memory: goes busy for mem_lat cycles per access, then waits for the strobes to drop.
    always @(posedge clock) begin
        if (reset) begin
            mem_busywait <= 1'b0;
            mem_readdata <= 32'h0;
            m_rel        <= 1'b0;
            m_cnt        <= 0;
            for (int i = 0; i < 64; i++) store[i] <= fill(i);
        end else if (mem_busywait) begin
            if (m_cnt == 1) begin
                mem_busywait <= 1'b0;
                m_rel        <= 1'b1;
                if (m_op_w) store[m_addr] <= m_wd;
                else        mem_readdata  <= store[m_addr];
            end
            m_cnt <= m_cnt - 1;
        end else if (m_rel) begin
            if (!mem_read && !mem_write) m_rel <= 1'b0;
        end else if (mem_read || mem_write) begin
            mem_busywait <= 1'b1;
            m_cnt        <= mem_lat;
            m_op_w       <= mem_write;
            m_addr       <= mem_address;
            m_wd         <= mem_writedata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 64; i++) ref_mem[i] = fill(i);
        d_exp    = 32'h0;
        i_exp    = 32'h0;
        last_exp = 1;
    endtask

    // One round: raise the given requests together and serve them to completion.
    task automatic do_round(input logic dr, input logic dw, input logic ir, input logic [5:0] da,
                            input logic [5:0] ia, input logic [31:0] dwd, input int lat);
        int   ord [2];
        int   n_exp, g, c, fall_k;
        bit   pb, ps, dp, ip;
        logic dreq, ow;
        dreq = dr | dw;
        g = 0; c = 0; fall_k = -10; pb = 0; ps = 0;
        if (dreq && ir) begin
            ord[0] = (RrEn && last_exp == 0) ? 1 : 0;
            ord[1] = 1 - ord[0];
            n_exp  = 2;
        end else begin
            ord[0] = dreq ? 0 : 1;
            ord[1] = ord[0];
            n_exp  = 1;
        end
        last_exp = ord[n_exp-1];
        mem_lat  = lat;
        @(negedge clock);
        d_read = dr; d_write = dw; d_address = da; d_writedata = dwd;
        i_read = ir; i_address = ia;
        dp = dreq; ip = ir;
        for (int k = 1; k <= 200 && (dp || ip); k++) begin
            @(posedge clock); #1;
            if ((mem_read || mem_write) && !ps) begin
                if (g < n_exp) begin
                    ow = (ord[g] == 0) && dw;
                    chk("grant_addr", 32'(mem_address), 32'(ord[g] == 0 ? da : ia));
                    chk("grant_wr", 32'(mem_write), 32'(ow));
                    chk("grant_rd", 32'(mem_read), 32'(!ow));
                    if (ow) chk("grant_wdata", mem_writedata, dwd);
                    if (g == 0) chk("req_to_strobe", 32'(k), 32'd1);
                end else begin
                    chk("extra_grant", 32'(g + 1), 32'(n_exp));
                end
                g++;
            end
            if (pb && !mem_busywait) fall_k = k;
            if (!dreq) chk("d_idle_busywait", 32'(d_busywait), 32'd0);
            if (!ir)   chk("i_idle_busywait", 32'(i_busywait), 32'd0);
            if (dp && d_busywait === 1'b0) begin
                chk("d_order", 32'(c < n_exp ? ord[c] : 9), 32'd0);
                chk("d_done_lat", 32'(k), 32'(fall_k + 1));
                chk("d_release_strobes", 32'(mem_read | mem_write), 32'd0);
                if (ip) chk("i_stalled", 32'(i_busywait), 32'd1);
                if (dw) ref_mem[da] = dwd;
                else    d_exp = ref_mem[da];
                chk("d_readdata", d_readdata, d_exp);
                chk("i_readdata_hold", i_readdata, i_exp);
                d_read = 1'b0; d_write = 1'b0; dp = 0; c++;
            end
            if (ip && i_busywait === 1'b0) begin
                chk("i_order", 32'(c < n_exp ? ord[c] : 9), 32'd1);
                chk("i_done_lat", 32'(k), 32'(fall_k + 1));
                chk("i_release_strobes", 32'(mem_read | mem_write), 32'd0);
                if (dp) chk("d_stalled", 32'(d_busywait), 32'd1);
                i_exp = ref_mem[ia];
                chk("i_readdata", i_readdata, i_exp);
                chk("d_readdata_hold", d_readdata, d_exp);
                i_read = 1'b0; ip = 0; c++;
            end
            ps = mem_read | mem_write;
            pb = mem_busywait;
        end
        if (dp || ip) chk("timeout", {30'b0, dp, ip}, 32'd0);
        @(posedge clock); #1;
        chk("idle_strobes", 32'(mem_read | mem_write), 32'd0);
    endtask

    initial begin
        logic       rdr, rdw, rir;
        logic [5:0] rda, ria;
        reset = 1'b1;
        d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
        i_read = 0; i_address = '0;
        ref_init();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        chk("rst_d_readdata", d_readdata, 32'd0);
        chk("rst_i_readdata", i_readdata, 32'd0);
        chk("rst_busywaits", {30'b0, d_busywait, i_busywait}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        do_round(1'b0, 1'b1, 1'b0, 6'h15, 6'h00, 32'hDEADBEEF, 2);
        do_round(1'b1, 1'b0, 1'b0, 6'h15, 6'h00, 32'h0, 5);
        do_round(1'b0, 1'b1, 1'b0, 6'h2A, 6'h00, 32'h12345678, 3);
        do_round(1'b1, 1'b0, 1'b1, 6'h01, 6'h02, 32'h0, 3);
        repeat (3) do_round(1'b1, 1'b0, 1'b1, 6'h01, 6'h02, 32'h0, 2);
        do_round(1'b0, 1'b0, 1'b1, 6'h00, 6'h2A, 32'h0, 2);
        do_round(1'b0, 1'b1, 1'b1, 6'h07, 6'h07, 32'hA5A55A5A, 1);

        // Reset while the dcache owns the bus.
        mem_lat = 4;
        @(negedge clock);
        d_read = 1'b1; d_address = 6'h33;
        @(posedge clock); #1;
        chk("midrst_strobe_up", 32'(mem_read), 32'd1);
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_strobes", 32'(mem_read | mem_write), 32'd0);
        chk("midrst_d_busy1", 32'(d_busywait), 32'd1);
        @(posedge clock); #1;
        chk("midrst_d_busy2", 32'(d_busywait), 32'd1);
        chk("midrst_d_readdata", d_readdata, 32'd0);
        @(negedge clock);
        reset = 1'b0; d_read = 1'b0;
        ref_init();
        repeat (3) begin
            @(posedge clock); #1;
            chk("postrst_no_strobe", 32'(mem_read | mem_write), 32'd0);
            chk("postrst_d_busy", 32'(d_busywait), 32'd0);
        end

        for (int r = 0; r < 24; r++) begin
            rdr = 1'($urandom_range(0, 1));
            rdw = 1'($urandom_range(0, 1));
            rir = 1'($urandom_range(0, 1));
            if (!rdr && !rdw && !rir) rir = 1'b1;
            rda = 6'($urandom_range(0, 63));
            ria = 6'($urandom_range(0, 63));
            do_round(rdr, rdw, rir, rda, ria, $urandom, int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
